forward_subst: RTL and testbench
================================

# forward_subst

Solves L·y = b for y by forward substitution, where L is a 4x4 signed lower-triangular matrix. Processes one multiply-accumulate per cycle through a small FSM. Sits ahead of the backward-substitution stage in the matrix-inverse datapath: its y_out feeds that stage's y input, and both stages use the same flattened packing.

## Interface
- W, default 32: element width in bits; signed two's complement.
- UNIT_DIAG, default 0: 1 = treat diagonal as 1 (Doolittle L); skip the division and never flag div_err.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- L_in  in  16*W  element (r,c) at bits [(r*4+c)*W +: W]; entries with c>r ignored.
- b_in  in  4*W  b[i] at bits [i*W +: W].
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; y_out valid from this cycle on.
- y_out  out  4*W  y[i] at bits [i*W +: W]; holds until the next DONE or reset.
- div_err  out  1  sticky; set when any used diagonal is 0; cleared when start is accepted.

## Operation
- States: IDLE, LOAD, ACC, DIV, DONE.
- IDLE:
  - If start=1: go to LOAD and clear div_err.
  - start in any other state is ignored.
- LOAD:
  - Register L_in and b_in into internal arrays. Inputs may change after this edge.
  - Set row i=0 and go to DIV, since row 0 has no ACC terms.
- ACC (row i, column j = 0..i-1, one per cycle):
  - acc := acc − L[i][j]·y[j].
  - acc is 2W bits, initialised to sign-extended b[i] when entering the row.
  - Product is the full 2W-bit signed result; the subtraction wraps at 2W bits.
  - After j=i−1, go to DIV.
- DIV (row i):
  - UNIT_DIAG=1: y[i] := acc[W-1:0].
  - UNIT_DIAG=0, L[i][i]≠0: y[i] := (acc / sign-extended L[i][i])[W-1:0]. Signed division, truncates toward zero.
  - UNIT_DIAG=0, L[i][i]=0: y[i] := 0 and div_err := 1. Later rows use y[i]=0.
  - If i<3: i := i+1, go to ACC. Otherwise go to DONE.
- DONE:
  - y_out := packed y, done := 1, go to IDLE.
- Reset values: state IDLE, busy 0, done 0, y_out 0, div_err 0; internal arrays and acc are 0.
- Reset mid-operation discards all work in progress. No done is produced for the aborted request.

## Timing
- Edge E0 samples start=1 in IDLE. busy is 1 after E0.
- State sequence after each edge:
  - E1: LOAD.
  - E2: DIV row 0.
  - E3: ACC; E4: DIV (row 1).
  - E5–E6: ACC; E7: DIV (row 2).
  - E8–E10: ACC; E11: DIV (row 3).
  - E12: DONE.
- After E12: done=1, y_out updated, busy=0 (back in IDLE). Latency is fixed at 12 cycles, independent of data and UNIT_DIAG.
- done falls after E13.
- start held high continuously: a new request is accepted at E13 (IDLE with start=1). Throughput is one solve per 13 cycles.
- div_err: cleared after the accepting edge E0; may set after any DIV edge; stable by the done cycle.
- No combinational paths from inputs to outputs.

## Test plan
- Identity L, b=(1,2,3,4) → y_out=(1,2,3,4), done exactly 12 cycles after start edge, single-cycle pulse, div_err=0.
- L rows (2,0,0,0),(1,1,0,0),(3,2,1,0),(1,1,1,4), b=(4,5,14,15) → y_out=(2,3,2,2). Upper-triangle garbage (e.g. 0xDEADBEEF) does not change the result.
- Truncation and sign: L=diag(3,−2,1,1), all off-diagonal 0, b=(−7,7,−1,0) → y_out=(−2,−3,−1,0).
- Divide-by-zero:
  - Test-2 matrix with L[1][1]=0 → y1=0, y0=2, y2=(14−6)/1=8, y3=(15−2−8)/4=1, div_err=1.
  - A following clean solve clears div_err.
- UNIT_DIAG=1, test-2 off-diagonals, all diagonals 0, b=(2,5,14,9) → y_out=(2,3,2,2), div_err=0.
- Control:
  - start pulsed during busy is ignored, and latency is unchanged.
  - rst asserted after E6 → next cycle busy=0, done=0, y_out=0, div_err=0.
  - A new start then completes with correct y_out in 12 cycles.

Source files
------------

// File: rtl/forward_subst_if.sv
// Handshake and data bundle for the forward-substitution stage.
// The master side drives the request; the slave side is the solver.
interface forward_subst_if #(
  parameter int W = 32
);
  logic            start;
  logic [16*W-1:0] L_in;
  logic [4*W-1:0]  b_in;
  logic            busy;
  logic            done;
  logic [4*W-1:0]  y_out;
  logic            div_err;

  modport master (
    output start, L_in, b_in,
    input  busy, done, y_out, div_err
  );

  modport slave (
    input  start, L_in, b_in,
    output busy, done, y_out, div_err
  );
endinterface

// File: rtl/forward_subst.sv
// Forward substitution L*y = b for a 4x4 signed lower-triangular L.
// One multiply-accumulate per cycle; fixed 12-cycle latency.
module forward_subst #(
  parameter int W         = 32,
  parameter bit UNIT_DIAG = 1'b0
) (
  input logic          clk,
  input logic          rst,
  forward_subst_if.slave io
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ACC, DIV, DONE
  } state_t;

  state_t state_q, state_d;

  logic        [1:0]     i_q, i_d;
  logic        [1:0]     j_q, j_d;
  logic signed [2*W-1:0] acc_q, acc_d;
  logic        [W-1:0]   l_q [16];
  logic        [W-1:0]   l_d [16];
  logic        [W-1:0]   b_q [4];
  logic        [W-1:0]   b_d [4];
  logic        [W-1:0]   y_q [4];
  logic        [W-1:0]   y_d [4];
  logic        [4*W-1:0] y_out_q, y_out_d;
  logic                  done_q, done_d;
  logic                  div_err_q, div_err_d;

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] diag;
  logic signed [2*W-1:0] quot;
  logic        [1:0]     i_nx;

  function automatic logic signed [2*W-1:0] sx(
    input logic [W-1:0] v
  );
    return {{W{v[W-1]}}, v};
  endfunction

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    l_d       = l_q;
    b_d       = b_q;
    y_d       = y_q;
    y_out_d   = y_out_q;
    done_d    = 1'b0;
    div_err_d = div_err_q;
    i_nx      = i_q + 2'd1;
    prod      = sx(l_q[{i_q, j_q}]) * sx(y_q[j_q]);
    diag      = sx(l_q[{i_q, i_q}]);
    quot      = '0;
    if (diag != '0) quot = acc_q / diag;

    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d   = LOAD;
          div_err_d = 1'b0;
        end
      end
      LOAD: begin
        for (int k = 0; k < 16; k++)
          l_d[k] = io.L_in[k*W +: W];
        for (int k = 0; k < 4; k++)
          b_d[k] = io.b_in[k*W +: W];
        i_d     = 2'd0;
        j_d     = 2'd0;
        acc_d   = sx(io.b_in[W-1:0]);
        state_d = DIV;
      end
      ACC: begin
        acc_d = acc_q - prod;
        if (j_q == i_q - 2'd1) state_d = DIV;
        else j_d = j_q + 2'd1;
      end
      DIV: begin
        if (UNIT_DIAG) begin
          y_d[i_q] = acc_q[W-1:0];
        end else if (diag == '0) begin
          y_d[i_q]  = '0;
          div_err_d = 1'b1;
        end else begin
          y_d[i_q] = quot[W-1:0];
        end
        if (i_q == 2'd3) begin
          state_d = DONE;
        end else begin
          i_d     = i_nx;
          j_d     = 2'd0;
          acc_d   = sx(b_q[i_nx]);
          state_d = ACC;
        end
      end
      DONE: begin
        for (int k = 0; k < 4; k++)
          y_out_d[k*W +: W] = y_q[k];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      y_out_q   <= '0;
      done_q    <= 1'b0;
      div_err_q <= 1'b0;
      for (int k = 0; k < 16; k++) l_q[k] <= '0;
      for (int k = 0; k < 4; k++) begin
        b_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      l_q       <= l_d;
      b_q       <= b_d;
      y_q       <= y_d;
      y_out_q   <= y_out_d;
      done_q    <= done_d;
      div_err_q <= div_err_d;
    end
  end

  assign io.busy    = (state_q != IDLE);
  assign io.done    = done_q;
  assign io.y_out   = y_out_q;
  assign io.div_err = div_err_q;

endmodule

// File: tb/tb_forward_subst.sv
// Bench for forward_subst: directed cases plus randomized solves
// against a plain-arithmetic substitution model.
module tb_forward_subst;
  localparam int W = 32;

  typedef logic [16*W-1:0] lmat_t;
  typedef logic [4*W-1:0]  vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forward_subst_if #(.W(W)) if0 ();
  forward_subst_if #(.W(W)) if1 ();

  forward_subst #(.W(W), .UNIT_DIAG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .io(if0.slave)
  );
  forward_subst #(.W(W), .UNIT_DIAG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .io(if1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic lmat_t pack_l(input int m[16]);
    lmat_t r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = m[k];
    return r;
  endfunction

  function automatic vec_t pack_v(input int v[4]);
    vec_t r;
    for (int k = 0; k < 4; k++) r[k*W +: W] = v[k];
    return r;
  endfunction

  // Substitution computed row by row in 64-bit arithmetic.
  task automatic model(input lmat_t l, input vec_t b, input bit unit,
                       output vec_t y, output bit err);
    longint acc, d, q;
    longint yv[4];
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = longint'($signed(b[i*W +: W]));
      for (int j = 0; j < i; j++)
        acc = acc - longint'($signed(l[(i*4+j)*W +: W])) * yv[j];
      if (unit) q = acc;
      else begin
        d = longint'($signed(l[(i*5)*W +: W]));
        if (d == 0) begin q = 0; err = 1'b1; end
        else q = acc / d;
      end
      y[i*W +: W] = q[W-1:0];
      yv[i] = longint'($signed(q[W-1:0]));
    end
  endtask

  task automatic drive(input bit unit, input logic st,
                       input lmat_t l, input vec_t b);
    if (unit) begin
      if1.start = st; if1.L_in = l; if1.b_in = b;
    end else begin
      if0.start = st; if0.L_in = l; if0.b_in = b;
    end
  endtask

  function automatic logic rd_done(input bit unit);
    return unit ? if1.done : if0.done;
  endfunction
  function automatic logic rd_busy(input bit unit);
    return unit ? if1.busy : if0.busy;
  endfunction
  function automatic logic rd_err(input bit unit);
    return unit ? if1.div_err : if0.div_err;
  endfunction
  function automatic vec_t rd_y(input bit unit);
    return unit ? if1.y_out : if0.y_out;
  endfunction

  // Runs one request and reports what was observed; no checking here.
  task automatic do_solve(input bit unit, input lmat_t l, input vec_t b,
                          input int pulse_at, output int lat,
                          output vec_t y, output logic err,
                          output logic busy0, output logic busy_d,
                          output int extra);
    lat = -1; y = 'x; err = 1'bx; busy_d = 1'bx; extra = 0;
    @(negedge clk);
    drive(unit, 1'b1, l, b);
    @(posedge clk); #1;
    busy0 = rd_busy(unit);
    drive(unit, 1'b0, l, b);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      drive(unit, (n == pulse_at), l, b);
      if (rd_done(unit)) begin
        lat = n;
        break;
      end
    end
    drive(unit, 1'b0, l, b);
    if (lat >= 0) begin
      y = rd_y(unit);
      err = rd_err(unit);
      busy_d = rd_busy(unit);
      for (int n = 0; n < 15; n++) begin
        @(posedge clk); #1;
        if (rd_done(unit)) extra++;
      end
    end
  endtask

  lmat_t l_t2;
  vec_t  b_t2;

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", if0.busy); end
    n_checks++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", if0.done); end
    n_checks++; if (if0.y_out !== '0) begin n_fail++; $display("FAIL rst_y: got %h want 0", if0.y_out); end
    n_checks++; if (if0.div_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", if0.div_err); end
    n_checks++; if (if1.y_out !== '0) begin n_fail++; $display("FAIL rst_y_u: got %h want 0", if1.y_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity;
    int m[16]; int v[4]; int lat, extra; vec_t y, exp; logic err, b0, bd;
    m = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    v = '{1,2,3,4};
    exp = pack_v(v);
    do_solve(1'b0, pack_l(m), pack_v(v), 0, lat, y, err, b0, bd, extra);
    n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL id_busy_e0: got %b want 1", b0); end
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL id_latency: got %0d want 12", lat); end
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL id_y: got %h want %h", y, exp); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL id_err: got %b want 0", err); end
    n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL id_busy_done: got %b want 0", bd); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL id_pulse: got %0d extra done cycles want 0", extra); end
  endtask

  task automatic test_example;
    int m[16]; int v[4]; int e[4]; int lat, extra; vec_t y, exp; logic err, b0, bd;
    m = '{2,32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,
          1,1,32'hDEADBEEF,32'hDEADBEEF,
          3,2,1,32'hDEADBEEF,
          1,1,1,4};
    v = '{4,5,14,15};
    e = '{2,3,2,2};
    l_t2 = pack_l(m); b_t2 = pack_v(v); exp = pack_v(e);
    do_solve(1'b0, l_t2, b_t2, 0, lat, y, err, b0, bd, extra);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL ex_latency: got %0d want 12", lat); end
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL ex_y: got %h want %h", y, exp); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ex_err: got %b want 0", err); end
  endtask

  task automatic test_trunc;
    int m[16]; int v[4]; int e[4]; int lat, extra; vec_t y, exp; logic err, b0, bd;
    m = '{3,0,0,0, 0,-2,0,0, 0,0,1,0, 0,0,0,1};
    v = '{-7,7,-1,0};
    e = '{-2,-3,-1,0};
    exp = pack_v(e);
    do_solve(1'b0, pack_l(m), pack_v(v), 0, lat, y, err, b0, bd, extra);
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL trunc_y: got %h want %h", y, exp); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL trunc_err: got %b want 0", err); end
  endtask

  task automatic test_div_zero;
    int e[4]; int lat, extra; vec_t y, exp; logic err, b0, bd; lmat_t l;
    l = l_t2;
    l[5*W +: W] = '0;
    e = '{2,0,8,1};
    exp = pack_v(e);
    do_solve(1'b0, l, b_t2, 0, lat, y, err, b0, bd, extra);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL dz_latency: got %0d want 12", lat); end
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL dz_y: got %h want %h", y, exp); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL dz_err: got %b want 1", err); end
    @(negedge clk);
    n_checks++; if (if0.div_err !== 1'b1) begin n_fail++; $display("FAIL dz_sticky: got %b want 1", if0.div_err); end
    do_solve(1'b0, l_t2, b_t2, 0, lat, y, err, b0, bd, extra);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dz_clear: got %b want 0", err); end
  endtask

  task automatic test_unit_diag;
    int v[4]; int e[4]; int lat, extra; vec_t y, exp; logic err, b0, bd; lmat_t l;
    l = l_t2;
    for (int i = 0; i < 4; i++) l[(i*5)*W +: W] = '0;
    v = '{2,5,14,9};
    e = '{2,3,2,2};
    exp = pack_v(e);
    do_solve(1'b1, l, pack_v(v), 0, lat, y, err, b0, bd, extra);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL ud_latency: got %0d want 12", lat); end
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL ud_y: got %h want %h", y, exp); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ud_err: got %b want 0", err); end
  endtask

  task automatic test_random;
    lmat_t l; vec_t b, y, exp; bit eerr; logic err, b0, bd;
    int lat, extra; bit unit;
    for (int t = 0; t < 24; t++) begin
      unit = t[0];
      for (int k = 0; k < 16; k++) l[k*W +: W] = $urandom;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c <= r; c++)
          l[(r*4+c)*W +: W] = $urandom_range(100) - 50;
        if ($urandom_range(7) == 0) l[(r*5)*W +: W] = '0;
        b[r*W +: W] = $urandom_range(4000) - 2000;
      end
      model(l, b, unit, exp, eerr);
      do_solve(unit, l, b, 0, lat, y, err, b0, bd, extra);
      n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want 12", t, lat); end
      n_checks++; if (y !== exp) begin n_fail++; $display("FAIL rnd_y[%0d]: got %h want %h", t, y, exp); end
      n_checks++; if (err !== eerr) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", t, err, eerr); end
    end
  endtask

  task automatic test_start_busy;
    int e[4]; int lat, extra; vec_t y, exp; logic err, b0, bd;
    e = '{2,3,2,2};
    exp = pack_v(e);
    do_solve(1'b0, l_t2, b_t2, 5, lat, y, err, b0, bd, extra);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL sb_latency: got %0d want 12", lat); end
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL sb_y: got %h want %h", y, exp); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL sb_extra: got %0d extra done cycles want 0", extra); end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    drive(1'b0, 1'b1, l_t2, b_t2);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (if0.done) begin
        if (first < 0) first = n;
        else begin second = n; break; end
      end
    end
    drive(1'b0, 1'b0, l_t2, b_t2);
    n_checks++; if (first !== 12) begin n_fail++; $display("FAIL b2b_first: got %0d want 12", first); end
    n_checks++; if (second !== 25) begin n_fail++; $display("FAIL b2b_second: got %0d want 25", second); end
    repeat (16) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int m[16]; int v[4]; int lat, extra, seen; vec_t y, exp; logic err, b0, bd; lmat_t l;
    l = l_t2;
    l[5*W +: W] = '0;
    do_solve(1'b0, l, b_t2, 0, lat, y, err, b0, bd, extra);
    m = '{1,0,0,0, 2,1,0,0, 0,3,1,0, 1,0,0,1};
    v = '{5,11,-1,9};
    exp = pack_v('{5,1,-4,4});
    @(negedge clk);
    drive(1'b0, 1'b1, pack_l(m), pack_v(v));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, pack_l(m), pack_v(v));
    for (int n = 1; n <= 6; n++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", if0.busy); end
    n_checks++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL rm_done: got %b want 0", if0.done); end
    n_checks++; if (if0.y_out !== '0) begin n_fail++; $display("FAIL rm_y: got %h want 0", if0.y_out); end
    n_checks++; if (if0.div_err !== 1'b0) begin n_fail++; $display("FAIL rm_err: got %b want 0", if0.div_err); end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (if0.done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d want 0", seen); end
    do_solve(1'b0, pack_l(m), pack_v(v), 0, lat, y, err, b0, bd, extra);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL rm_latency: got %0d want 12", lat); end
    n_checks++; if (y !== exp) begin n_fail++; $display("FAIL rm_y_after: got %h want %h", y, exp); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_example();
    test_trunc();
    test_div_zero();
    test_unit_diag();
    test_random();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
